// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selector for a shared tri-state bus with a one-cycle turnaround.
// Define BUS_ARBITER_TIMEOUT_EN to add the grant watchdog, timeout pulse and exclusion mask.
module bus_arbiter #(
    parameter int  requester_num  = 4,
    parameter int  timeout_cycles = 16,
    localparam int IW = (requester_num > 1) ? $clog2(requester_num) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [requester_num-1:0] req,
    output logic [requester_num-1:0] grant,
    output logic [IW-1:0]            grant_idx,
    output logic                     grant_valid,
    output logic                     timeout
);

    // IDLE: no owner, bus idle | GRANT: owner drives bus | TURN: one dead cycle between owners
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IW-1:0]            r_owner;
    logic [IW-1:0]            w_owner_nxt;
    logic [IW-1:0]            r_ptr;
    logic [IW-1:0]            w_ptr_nxt;
    logic [IW-1:0]            w_owner_inc;
    logic [IW-1:0]            w_win_idx;
    logic [requester_num-1:0] r_grant;
    logic [requester_num-1:0] w_grant_nxt;
    logic [requester_num-1:0] w_eligible;
    logic                     w_win_found;
    logic                     w_expire;
    int                       w_scan;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0]            r_cnt;
    logic [requester_num-1:0] r_mask;
    logic [requester_num-1:0] w_mask_set;
    logic                     r_timeout;
    logic                     w_revoke;

    assign w_expire   = (r_cnt == CW'(timeout_cycles - 1));
    assign w_revoke   = (r_state == S_GRANT) && req[r_owner] && w_expire;
    assign w_eligible = req & ~r_mask;

    always_comb begin
        w_mask_set = '0;
        if (w_revoke) w_mask_set[r_owner] = 1'b1;
    end

    // A revoked requester stays excluded until it lets go of req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mask    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (r_state == S_GRANT && w_state_nxt == S_GRANT) ? r_cnt + 1'b1 : '0;
            r_mask    <= (r_mask & req) | w_mask_set;
            r_timeout <= w_revoke;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire   = (timeout_cycles < 1);  // watchdog compiled out; always low for legal settings
    assign w_eligible = req;
    assign timeout    = 1'b0;
`endif

    assign w_owner_inc = (r_owner == IW'(requester_num - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = 0;
        for (int k = 0; k < requester_num; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= requester_num) w_scan = w_scan - requester_num;
            if (!w_win_found && w_eligible[IW'(w_scan)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(w_scan);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = '0;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_win_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_win_idx;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!req[r_owner] || w_expire) begin
                    w_state_nxt = S_TURN;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    w_owner_nxt = r_owner;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        if (w_state_nxt == S_GRANT) w_grant_nxt[w_owner_nxt] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_owner;
    assign grant_valid = |r_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter (N=4 and N=3) against a rule-level model.
// Honours BUS_ARBITER_TIMEOUT_EN so the same bench covers both builds.
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req4, grant4;
    logic [1:0] idx4;
    logic       valid4, to4;
    logic [2:0] req3, grant3;
    logic [1:0] idx3;
    logic       valid3, to3;

    int vectors     = 0;
    int miscompares = 0;

    // model: current owner (-1 = bus free), rotation start, held cycles, exclusion set, timeout pulse
    int         m_owner[2];
    int         m_ptr[2];
    int         m_cnt[2];
    logic [3:0] m_mask[2];
    bit         m_to[2];

    logic [3:0] r4;
    logic [2:0] r3;

    bus_arbiter #(.requester_num(4), .timeout_cycles(TO)) u_dut4 (
        .clk(clk), .reset(reset), .req(req4), .grant(grant4),
        .grant_idx(idx4), .grant_valid(valid4), .timeout(to4)
    );

    bus_arbiter #(.requester_num(3), .timeout_cycles(TO)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .grant(grant3),
        .grant_idx(idx3), .grant_valid(valid3), .timeout(to3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_cnt[k]   = 0;
            m_mask[k]  = '0;
            m_to[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int n, w, c;
        logic [3:0] nm;
        n  = (k == 0) ? 4 : 3;
        nm = m_mask[k] & r;
        m_to[k] = 1'b0;
        if (m_owner[k] >= 0) begin
            if (!r[m_owner[k]] || (WD_ON && m_cnt[k] + 1 >= TO)) begin
                if (r[m_owner[k]]) begin
                    nm[m_owner[k]] = 1'b1;
                    m_to[k] = 1'b1;
                end
                m_ptr[k]   = (m_owner[k] + 1) % n;
                m_owner[k] = -1;
            end else begin
                m_cnt[k]++;
            end
        end else begin
            w = -1;
            for (int j = 0; j < n; j++) begin
                c = (m_ptr[k] + j) % n;
                if (w < 0 && r[c] && !m_mask[k][c]) w = c;
            end
            if (w >= 0) begin
                m_owner[k] = w;
                m_cnt[k]   = 0;
            end
        end
        m_mask[k] = nm;
    endtask

    function automatic logic [31:0] exp_grant(input int k);
        return (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_idx(input int k);
        return (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0;
    endfunction

    task automatic check_models();
        check("n4.grant", grant4, exp_grant(0));
        check("n4.idx", idx4, exp_idx(0));
        check("n4.valid", valid4, 32'(m_owner[0] >= 0));
        check("n4.timeout", to4, 32'(m_to[0]));
        check("n3.grant", grant3, exp_grant(1));
        check("n3.idx", idx3, exp_idx(1));
        check("n3.valid", valid3, 32'(m_owner[1] >= 0));
        check("n3.timeout", to3, 32'(m_to[1]));
    endtask

    task automatic tick(input logic [3:0] a4, input logic [2:0] a3);
        req4 = a4;
        req3 = a3;
        @(posedge clk);
        model_step(0, a4);
        model_step(1, {1'b0, a3});
        #1;
        check_models();
    endtask

    // called just after an active edge; reset pulse never coincides with a clock edge
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_models();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req4  = '0;
        req3  = '0;
        r4    = '0;
        r3    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_models();
        reset = 1'b0;

        // single request, release, turnaround, idle
        tick(4'b0100, 3'b000);
        check("single.grant", grant4, 32'h4);
        check("single.idx", idx4, 32'd2);
        tick(4'b0000, 3'b000);
        check("single.turn", grant4, 32'h0);
        tick(4'b0000, 3'b000);
        check("single.idle", grant4, 32'h0);

        // all requesting, each owner holds two cycles then releases
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'hF, 3'b000);
            check("rr.order", grant4, 32'd1 << (i % 4));
            tick(4'hF, 3'b000);
            check("rr.hold", grant4, 32'd1 << (i % 4));
            tick(4'hF & ~(4'b0001 << (i % 4)), 3'b000);
            check("rr.gap", grant4, 32'h0);
        end

        // N=3: owner 2 releases while 0 and 1 request, pointer wraps to 0
        pulse_reset();
        tick(4'b0000, 3'b100);
        check("wrap.own2", grant3, 32'h4);
        tick(4'b0000, 3'b111);
        tick(4'b0000, 3'b011);
        check("wrap.turn", grant3, 32'h0);
        tick(4'b0000, 3'b011);
        check("wrap.grant0", grant3, 32'h1);
        check("wrap.idx0", idx3, 32'd0);

        // asynchronous reset mid-grant
        pulse_reset();
        tick(4'b0010, 3'b000);
        check("areset.pre", grant4, 32'h2);
        reset = 1'b1;
        #1;
        check("areset.grant", grant4, 32'h0);
        check("areset.idx", idx4, 32'd0);
        check("areset.valid", valid4, 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
        tick(4'hF, 3'b000);
        check("areset.ptr0", grant4, 32'h1);

        // held requests: watchdog revokes, or grant held forever without it
        pulse_reset();
        if (WD_ON) begin
            for (int c = 0; c < TO; c++) begin
                tick(4'b0011, 3'b000);
                check("wd.hold", grant4, 32'h1);
                check("wd.quiet", to4, 32'd0);
            end
            tick(4'b0011, 3'b000);
            check("wd.revoke", grant4, 32'h0);
            check("wd.pulse", to4, 32'd1);
            tick(4'b0011, 3'b000);
            check("wd.next", grant4, 32'h2);
            check("wd.pulse_end", to4, 32'd0);
            for (int c = 0; c < TO + 2; c++) begin
                tick(4'b0011, 3'b000);
                check("wd.excluded", grant4[0], 32'd0);
            end
            tick(4'b0010, 3'b000);
            check("wd.masked", grant4, 32'h0);
            tick(4'b0011, 3'b000);
            check("wd.regrant", grant4, 32'h1);
        end else begin
            for (int c = 0; c < 20; c++) begin
                tick(4'b0011, 3'b000);
                check("nowd.hold", grant4, 32'h1);
                check("nowd.timeout", to4, 32'd0);
            end
        end

        // random hold-style traffic on both instances
        pulse_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) r4[b] = ~r4[b];
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) r3[b] = ~r3[b];
            tick(r4, r3);
            if ($urandom_range(0, 149) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
